// File: rtl/corevx_ptw_arbiter_if.sv
// Bundle of the two TLB miss ports and the walker handshake shared by the PTW arbiter.
// The slave modport is the arbiter; the master modport is the TLBs and walker side.
interface corevx_ptw_arbiter_if;
  logic        r0_request;
  logic [19:0] r0_virtual_address;
  logic        r0_done;
  logic        r0_pagefault;
  logic        r0_accessfault;
  logic [7:0]  r0_access_bits;
  logic [21:0] r0_physical_address;

  logic        r1_request;
  logic [19:0] r1_virtual_address;
  logic        r1_done;
  logic        r1_pagefault;
  logic        r1_accessfault;
  logic [7:0]  r1_access_bits;
  logic [21:0] r1_physical_address;

  logic        ptw_resolve_request;
  logic        ptw_resolve_ack;
  logic [19:0] ptw_virtual_address;
  logic        ptw_resolve_done;
  logic        ptw_resolve_pagefault;
  logic        ptw_resolve_accessfault;
  logic [7:0]  ptw_resolve_access_bits;
  logic [21:0] ptw_resolve_physical_address;

  modport slave (
    input  r0_request, r0_virtual_address, r1_request, r1_virtual_address,
    output r0_done, r0_pagefault, r0_accessfault, r0_access_bits, r0_physical_address,
    output r1_done, r1_pagefault, r1_accessfault, r1_access_bits, r1_physical_address,
    output ptw_resolve_request, ptw_virtual_address,
    input  ptw_resolve_ack, ptw_resolve_done, ptw_resolve_pagefault,
    input  ptw_resolve_accessfault, ptw_resolve_access_bits, ptw_resolve_physical_address
  );

  modport master (
    output r0_request, r0_virtual_address, r1_request, r1_virtual_address,
    input  r0_done, r0_pagefault, r0_accessfault, r0_access_bits, r0_physical_address,
    input  r1_done, r1_pagefault, r1_accessfault, r1_access_bits, r1_physical_address,
    input  ptw_resolve_request, ptw_virtual_address,
    output ptw_resolve_ack, ptw_resolve_done, ptw_resolve_pagefault,
    output ptw_resolve_accessfault, ptw_resolve_access_bits, ptw_resolve_physical_address
  );
endinterface

// File: rtl/corevx_ptw_arbiter.sv
// Round-robin share of one page table walker between ITLB (port 0) and DTLB (port 1); 3 cycles + walker latency.
// Backpressure: the walk request holds in ISSUE until the walker acks; one walk in flight at a time.
module corevx_ptw_arbiter (
  input  logic               clk,
  input  logic               rst_n,
  corevx_ptw_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ISSUE   = 2'd1,
    S_WAIT    = 2'd2,
    S_RESPOND = 2'd3
  } state_t;

  typedef struct packed {
    logic        pagefault;
    logic        accessfault;
    logic [7:0]  access_bits;
    logic [21:0] physical_address;
  } res_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic        r_grant;
  logic        r_last_grant;
  logic [19:0] r_vaddr;
  res_t        r_res0;
  res_t        r_res1;
  res_t        w_res_in;
  logic        w_any_req;
  logic        w_win;

  assign w_any_req = bus.r0_request | bus.r1_request;
  // On a tie the port that did not win last time goes first.
  assign w_win     = (bus.r0_request && bus.r1_request) ? ~r_last_grant : bus.r1_request;
  assign w_res_in  = {bus.ptw_resolve_pagefault, bus.ptw_resolve_accessfault,
                      bus.ptw_resolve_access_bits, bus.ptw_resolve_physical_address};

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:    if (w_any_req)            w_state_nxt = S_ISSUE;
      S_ISSUE:   if (bus.ptw_resolve_ack)  w_state_nxt = S_WAIT;
      S_WAIT:    if (bus.ptw_resolve_done) w_state_nxt = S_RESPOND;
      S_RESPOND:                           w_state_nxt = S_IDLE;
      default:                             w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_grant      <= 1'b0;
      r_last_grant <= 1'b1;
      r_vaddr      <= '0;
      r_res0       <= '0;
      r_res1       <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == S_IDLE && w_any_req) begin
        r_grant <= w_win;
        r_vaddr <= w_win ? bus.r1_virtual_address : bus.r0_virtual_address;
      end
      if (r_state == S_WAIT && bus.ptw_resolve_done) begin
        if (r_grant) r_res1 <= w_res_in;
        else         r_res0 <= w_res_in;
      end
      if (r_state == S_RESPOND) r_last_grant <= r_grant;
    end
  end

  assign bus.ptw_resolve_request = (r_state == S_ISSUE);
  assign bus.ptw_virtual_address = r_vaddr;

  assign bus.r0_done             = (r_state == S_RESPOND) && !r_grant;
  assign bus.r0_pagefault        = r_res0.pagefault;
  assign bus.r0_accessfault      = r_res0.accessfault;
  assign bus.r0_access_bits      = r_res0.access_bits;
  assign bus.r0_physical_address = r_res0.physical_address;

  assign bus.r1_done             = (r_state == S_RESPOND) && r_grant;
  assign bus.r1_pagefault        = r_res1.pagefault;
  assign bus.r1_accessfault      = r_res1.accessfault;
  assign bus.r1_access_bits      = r_res1.access_bits;
  assign bus.r1_physical_address = r_res1.physical_address;

endmodule

// File: tb/tb_corevx_ptw_arbiter.sv
// Scoreboard bench for corevx_ptw_arbiter: directed walks, walker model, decoupled monitor.
module tb_corevx_ptw_arbiter;

  typedef struct packed {
    logic        pf;
    logic        af;
    logic [7:0]  bits;
    logic [21:0] pa;
  } res_t;

  typedef struct {
    int   ack_dly;
    int   done_dly;
    res_t res;
  } walk_t;

  typedef struct {
    logic [19:0] va;
    int          stall;
  } iss_t;

  typedef struct {
    int   port;
    res_t r0;
    res_t r1;
    int   exp_cyc;
  } exp_t;

  logic clk;
  logic rst_n;
  int   cyc;
  int   checks;
  int   errors;

  walk_t wq[$];
  iss_t  iq[$];
  exp_t  rq[$];

  corevx_ptw_arbiter_if bus ();

  corevx_ptw_arbiter dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic res_t r0_now();
    return {bus.r0_pagefault, bus.r0_accessfault, bus.r0_access_bits, bus.r0_physical_address};
  endfunction

  function automatic res_t r1_now();
    return {bus.r1_pagefault, bus.r1_accessfault, bus.r1_access_bits, bus.r1_physical_address};
  endfunction

  // Walker model: serves queued responses whenever a request is presented.
  initial begin
    walk_t w;
    bus.ptw_resolve_ack              = 1'b0;
    bus.ptw_resolve_done             = 1'b0;
    bus.ptw_resolve_pagefault        = 1'b0;
    bus.ptw_resolve_accessfault      = 1'b0;
    bus.ptw_resolve_access_bits      = '0;
    bus.ptw_resolve_physical_address = '0;
    forever begin
      @(posedge clk); #1;
      if (bus.ptw_resolve_request && wq.size() > 0) begin
        w = wq.pop_front();
        repeat (w.ack_dly) begin @(posedge clk); #1; end
        bus.ptw_resolve_ack = 1'b1;
        @(posedge clk); #1;
        bus.ptw_resolve_ack = 1'b0;
        repeat (w.done_dly) begin @(posedge clk); #1; end
        bus.ptw_resolve_done             = 1'b1;
        bus.ptw_resolve_pagefault        = w.res.pf;
        bus.ptw_resolve_accessfault      = w.res.af;
        bus.ptw_resolve_access_bits      = w.res.bits;
        bus.ptw_resolve_physical_address = w.res.pa;
        @(posedge clk); #1;
        bus.ptw_resolve_done = 1'b0;
      end
    end
  end

  // Monitor: checks issued walks and completions against the queues.
  bit chk_wait = 1'b0;
  int stall_cnt = 0;
  always @(negedge clk) begin
    exp_t e;
    iss_t s;
    if (chk_wait) begin
      chk("req_drop_in_wait", {31'd0, bus.ptw_resolve_request}, 32'd0);
      chk_wait = 1'b0;
    end
    if (bus.ptw_resolve_request) begin
      if (iq.size() == 0) begin
        chk("unexpected_issue", 32'd1, 32'd0);
      end else begin
        s = iq[0];
        chk("ptw_va", {12'd0, bus.ptw_virtual_address}, {12'd0, s.va});
        if (bus.ptw_resolve_ack) begin
          chk("ack_stall", stall_cnt, s.stall);
          void'(iq.pop_front());
          stall_cnt = 0;
          chk_wait  = 1'b1;
        end else begin
          stall_cnt++;
        end
      end
    end
    if (bus.r0_done || bus.r1_done) begin
      if (bus.r0_done && bus.r1_done) chk("both_done", 32'd1, 32'd0);
      if (rq.size() == 0) begin
        chk("unexpected_done", {30'd0, bus.r1_done, bus.r0_done}, 32'd0);
      end else begin
        e = rq.pop_front();
        chk("done_port", {31'd0, bus.r1_done}, e.port);
        chk("r0_result", r0_now(), e.r0);
        chk("r1_result", r1_now(), e.r1);
        if (e.exp_cyc >= 0) chk("done_latency", cyc, e.exp_cyc);
      end
    end
  end

  task automatic expect_walk(input int port, input logic [19:0] va, input int stall,
                             input int done_dly, input res_t res, input res_t r0,
                             input res_t r1, input int exp_cyc);
    wq.push_back('{ack_dly: stall, done_dly: done_dly, res: res});
    iq.push_back('{va: va, stall: stall});
    rq.push_back('{port: port, r0: r0, r1: r1, exp_cyc: exp_cyc});
  endtask

  task automatic wait_done(input int port);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(port == 0 ? bus.r0_done : bus.r1_done) && n < 200);
    if (n >= 200) chk($sformatf("timeout_done_p%0d", port), 32'd0, 32'd1);
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_pulses"}, {29'd0, bus.r0_done, bus.r1_done, bus.ptw_resolve_request}, 32'd0);
    chk({tag, "_r0"}, r0_now(), 32'd0);
    chk({tag, "_r1"}, r1_now(), 32'd0);
    chk({tag, "_va"}, {12'd0, bus.ptw_virtual_address}, 32'd0);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 1'b0;
    bus.r0_request = 1'b0;
    bus.r1_request = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    check_idle_outputs("reset");
    rst_n = 1'b1;
  endtask

  task automatic single_walk(input int port, input logic [19:0] va);
    @(posedge clk); #1;
    if (port == 0) begin bus.r0_request = 1'b1; bus.r0_virtual_address = va; end
    else           begin bus.r1_request = 1'b1; bus.r1_virtual_address = va; end
    wait_done(port);
    @(posedge clk); #1;
    if (port == 0) bus.r0_request = 1'b0;
    else           bus.r1_request = 1'b0;
  endtask

  localparam res_t ZERO   = '0;
  localparam res_t R_A    = {1'b0, 1'b0, 8'hCF, 22'h3ABCD};
  localparam res_t R_AAA  = {1'b0, 1'b0, 8'h01, 22'h00AAA};
  localparam res_t R_BBB  = {1'b0, 1'b0, 8'h02, 22'h00BBB};
  localparam res_t R_CCC  = {1'b0, 1'b0, 8'h03, 22'h00CCC};
  localparam res_t R_STL  = {1'b0, 1'b0, 8'h7F, 22'h2AAAA};
  localparam res_t R_AF   = {1'b0, 1'b1, 8'h55, 22'h12345};
  localparam res_t R_PF   = {1'b1, 1'b0, 8'h00, 22'h00000};
  localparam res_t R_DROP = {1'b0, 1'b0, 8'hEE, 22'h3FFFF};
  localparam res_t R_888  = {1'b0, 1'b0, 8'h11, 22'h01111};
  localparam res_t R_999  = {1'b0, 1'b0, 8'h22, 22'h02222};

  initial begin
    int n;
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    bus.r0_request = 1'b0;
    bus.r0_virtual_address = '0;
    bus.r1_request = 1'b0;
    bus.r1_virtual_address = '0;
    repeat (3) @(posedge clk);
    #1;
    check_idle_outputs("por");
    rst_n = 1'b1;

    // Single walk at minimum latency: done in first WAIT cycle.
    @(posedge clk); #1;
    expect_walk(0, 20'h12345, 0, 0, R_A, R_A, ZERO, cyc + 3);
    bus.r0_request = 1'b1;
    bus.r0_virtual_address = 20'h12345;
    wait_done(0);
    @(posedge clk); #1;
    bus.r0_request = 1'b0;

    // Simultaneous requests after reset; port 0 re-requests immediately.
    do_reset();
    @(posedge clk); #1;
    expect_walk(0, 20'h00011, 0, 2, R_AAA, R_AAA, ZERO, cyc + 5);
    expect_walk(1, 20'h00022, 0, 1, R_BBB, R_AAA, R_BBB, -1);
    expect_walk(0, 20'h00033, 0, 0, R_CCC, R_CCC, R_BBB, -1);
    bus.r0_request = 1'b1;
    bus.r0_virtual_address = 20'h00011;
    bus.r1_request = 1'b1;
    bus.r1_virtual_address = 20'h00022;
    fork
      begin
        wait_done(0);
        @(posedge clk); #1;
        bus.r0_virtual_address = 20'h00033;
        wait_done(0);
        @(posedge clk); #1;
        bus.r0_request = 1'b0;
      end
      begin
        wait_done(1);
        @(posedge clk); #1;
        bus.r1_request = 1'b0;
      end
    join

    // Ack held off for 5 cycles in ISSUE.
    expect_walk(0, 20'h0F0F0, 5, 0, R_STL, R_STL, R_BBB, -1);
    single_walk(0, 20'h0F0F0);

    // Access fault on port 1, then page fault on port 0.
    expect_walk(1, 20'h00444, 0, 1, R_AF, R_STL, R_AF, -1);
    single_walk(1, 20'h00444);
    expect_walk(0, 20'h00555, 0, 0, R_PF, R_PF, R_AF, -1);
    single_walk(0, 20'h00555);

    // Reset while in WAIT; the late walker result must be ignored.
    wq.push_back('{ack_dly: 0, done_dly: 4, res: R_DROP});
    iq.push_back('{va: 20'h00777, stall: 0});
    @(posedge clk); #1;
    bus.r0_request = 1'b1;
    bus.r0_virtual_address = 20'h00777;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.ptw_resolve_ack && n < 50);
    if (n >= 50) chk("timeout_ack", 32'd0, 32'd1);
    @(posedge clk); #1;
    rst_n = 1'b0;
    bus.r0_request = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    check_idle_outputs("midwalk_reset");
    rst_n = 1'b1;
    repeat (8) begin @(posedge clk); #1; end
    check_idle_outputs("after_stale_done");

    // Tie after reset goes to port 0 first.
    expect_walk(0, 20'h00888, 0, 0, R_888, R_888, ZERO, cyc + 3);
    expect_walk(1, 20'h00999, 0, 0, R_999, R_888, R_999, -1);
    bus.r0_request = 1'b1;
    bus.r0_virtual_address = 20'h00888;
    bus.r1_request = 1'b1;
    bus.r1_virtual_address = 20'h00999;
    fork
      begin
        wait_done(0);
        @(posedge clk); #1;
        bus.r0_request = 1'b0;
      end
      begin
        wait_done(1);
        @(posedge clk); #1;
        bus.r1_request = 1'b0;
      end
    join

    n = 0;
    while ((rq.size() != 0 || iq.size() != 0) && n < 200) begin
      @(posedge clk);
      n++;
    end
    repeat (4) @(posedge clk);
    chk("rq_drained", rq.size(), 32'd0);
    chk("iq_drained", iq.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/corevx_ptw_arbiter.md
# corevx_ptw_arbiter

- Shares the single page table walker between the instruction-fetch TLB (port 0) and the data TLB (port 1).
- Arbitrates between them round-robin and drives the walker's request/ack handshake.
- Captures the walker's single-cycle result and returns it to the granted port as a registered one-cycle completion pulse.
- Sits between both TLB miss paths and the walker; exactly one walk is in flight at any time.

## Interface
Parameters: none. The two ports are fixed.

Ports (clock and reset first):
- clk  in  1  clock
- rst_n  in  1  reset; synchronous, active-low
- rN_request  in  1  port N (N=0,1) walk request; level, held until rN_done
- rN_virtual_address  in  20  port N VPN[1:0]; stable while rN_request=1
- rN_done  out  1  port N completion pulse, exactly one cycle
- rN_pagefault  out  1  port N result: page fault
- rN_accessfault  out  1  port N result: access fault
- rN_access_bits  out  8  port N PTE access bits
- rN_physical_address  out  22  port N resolved PPN
- ptw_resolve_request  out  1  walk request to the walker
- ptw_resolve_ack  in  1  walker idle, accepts request this cycle
- ptw_virtual_address  out  20  VPN to the walker
- ptw_resolve_done  in  1  walker result valid (this cycle only)
- ptw_resolve_pagefault  in  1  walker page fault
- ptw_resolve_accessfault  in  1  walker access fault
- ptw_resolve_access_bits  in  8  walker access bits
- ptw_resolve_physical_address  in  22  walker PPN

## Operation
FSM states: IDLE, ISSUE, WAIT, RESPOND.

- **IDLE**
  - If no request is pending, stay in IDLE.
  - Else pick a winner. Single requester wins outright. If both request, the winner is the port != last_grant.
  - Latch grant and the winner's rN_virtual_address into ptw_virtual_address; go to ISSUE.
- **ISSUE**
  - ptw_resolve_request=1.
  - On ptw_resolve_ack=1, go to WAIT. Otherwise hold in ISSUE with the request and address unchanged.
- **WAIT**
  - ptw_resolve_request=0.
  - On ptw_resolve_done=1, register pagefault, accessfault, access_bits and physical_address into the granted port's result registers only; go to RESPOND.
- **RESPOND**
  - r{grant}_done=1 for one cycle.
  - last_grant <= grant; go to IDLE.

Result registers:
- Each port's result registers hold their value until that port's next completion.
- The other port's registers are never touched.

Requester rules:
- Keep rN_request asserted until rN_done.
- Deassert rN_request in the cycle after rN_done, unless issuing a new walk. A request still high in IDLE is treated as a new request.
- A port whose request drops mid-walk still receives its rN_done pulse; the requester ignores it.

Fault encoding:
- Faults pass through unmodified.
- pagefault and accessfault are never both 1.
- On a fault, access_bits and physical_address are latched as received and are don't-care to the requester.

## Timing
Reset values:
- state=IDLE, last_grant=1 (port 0 wins the first tie), grant=0.
- ptw_resolve_request=0, ptw_virtual_address=0.
- All rN_done, rN_pagefault, rN_accessfault, rN_access_bits and rN_physical_address = 0.

Reset mid-operation:
- Returns to IDLE immediately and drops any in-flight result; no rN_done is issued.
- The walker shares the same reset.

Outputs:
- ptw_resolve_request is a decode of state==ISSUE.
- ptw_virtual_address is registered.
- rN_done is a decode of state==RESPOND and grant==N.
- All rN_* result outputs are registered.

Minimum latency:
- Request seen in IDLE at cycle 0.
- ISSUE at cycle 1 (ack=1).
- WAIT at cycle 2; earliest ptw_resolve_done is in cycle 2.
- rN_done in cycle 3. Latency is 3 cycles plus walker memory latency.

Throughput and fairness:
- Back-to-back walks from alternating ports are separated by 1 IDLE cycle.
- With both ports continuously requesting, grants strictly alternate 0,1,0,1 and no port waits more than one walk.

Edge cases:
- ptw_resolve_done outside WAIT is ignored.
- ptw_resolve_ack outside ISSUE is ignored.
- A new request arriving during ISSUE, WAIT or RESPOND is not sampled until IDLE.

## Test plan
- **Single walk:** r0 request, VA=0x12345; walker returns done with PA=0x3ABCD, bits=0xCF.
  - ptw_virtual_address=0x12345.
  - r0_done pulses once; r0_physical_address=0x3ABCD, r0_access_bits=0xCF.
  - r1 outputs stay 0.
- **Simultaneous after reset:** r0 and r1 request in the same cycle.
  - Port 0 granted first.
  - Port 1 then granted with no further port-0 walk in between, even though r0 re-requests immediately.
- **Stalled ack:** hold ptw_resolve_ack=0 for 5 cycles in ISSUE.
  - ptw_resolve_request stays 1 with a stable address.
  - Moves to WAIT on the cycle ack=1.
- **Faults:** r1 walk ends with accessfault=1.
  - r1_accessfault=1, r1_pagefault=0.
  - A following r0 pagefault walk sets only r0_pagefault; r1 result registers are unchanged.
- **Reset mid-walk:** assert rst_n=0 while in WAIT.
  - All outputs return to 0; no rN_done is issued.
  - The next request after reset behaves as after power-on (port 0 wins a tie).
- **Minimum latency:** walker returns done in the first WAIT cycle.
  - rN_done is asserted exactly 3 cycles after the request is seen in IDLE.
